// File: rtl/regfile_pkg.sv
// Shared constants, clear-FSM state type and write-arbitration helper for the multi-port regfile.
// Purely declarative; no timing or flow control of its own.
package regfile_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 5;
  localparam int DEPTH_DEF  = 32;
  localparam int MAX_WRITE  = 2;

  typedef enum logic {CLEAR, READY} clr_state_e;

  // hit[j] means write port j commits to the address; the highest-index port wins
  function automatic int win_port(input logic [MAX_WRITE-1:0] hit);
    win_port = 0;
    for (int j = 0; j < MAX_WRITE; j++) begin
      if (hit[j]) win_port = j;
    end
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks a pointer over every entry emitting one zero-write per cycle.
// Busy from reset release or clr acceptance for exactly DEPTH cycles; clr ignored while busy.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [AWIDTH-1:0] clr_wa_o
);

  clr_state_e        state_q, state_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + AWIDTH'(1);
        if (ptr_q == AWIDTH'(DEPTH - 1)) begin
          state_d = READY;
          ptr_d   = '0;
        end
      end
      READY: begin
        if (clr_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign busy_o   = (state_q == CLEAR);
  assign clr_we_o = (state_q == CLEAR);
  assign clr_wa_o = ptr_q;

endmodule

// File: rtl/regfile_mp.sv
// NREAD x NWRITE register file, 1-cycle registered reads with write-first bypass, optional zero reg.
// No backpressure; user writes are dropped and reads return 0 while the clear sequencer is busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int AWIDTH   = AWIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREAD*AWIDTH-1:0]  ra,
  output logic [NREAD*DWIDTH-1:0]  rd,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*AWIDTH-1:0] wa,
  input  logic [NWRITE*DWIDTH-1:0] wd,
  input  logic                     clr,
  output logic                     busy,
  output logic                     wcollide
);

  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);

  logic                 clr_we;
  logic [AWIDTH-1:0]    clr_wa;
  logic [DWIDTH-1:0]    mem_q [DEPTH];
  logic [AWIDTH-1:0]    wa_a [NWRITE];
  logic [DWIDTH-1:0]    wd_a [NWRITE];
  logic [NWRITE-1:0]    wr_ok;
  logic [MAX_WRITE-1:0] wr_hit [DEPTH];
  logic [DWIDTH-1:0]    wr_dat [DEPTH];
  logic [AWIDTH-1:0]    ra_a [NREAD];
  logic [DWIDTH-1:0]    rd_d [NREAD];
  logic [NREAD*DWIDTH-1:0] rd_q;
  logic                 wcollide_q, wcollide_d;

  regfile_clear_seq #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clr),
    .busy_o   (busy),
    .clr_we_o (clr_we),
    .clr_wa_o (clr_wa)
  );

  // Out-of-range and zero-register addresses are neither stored nor read
  function automatic logic addr_ok(input logic [AWIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    for (int j = 0; j < NWRITE; j++) begin
      wa_a[j]  = wa[j*AWIDTH +: AWIDTH];
      wd_a[j]  = wd[j*DWIDTH +: DWIDTH];
      wr_ok[j] = we[j] && !clr_we && addr_ok(wa_a[j]);
    end
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wr_hit[e] = '0;
      wr_dat[e] = '0;
      for (int j = 0; j < NWRITE; j++) begin
        wr_hit[e][j] = wr_ok[j] && (wa_a[j] == AWIDTH'(e));
      end
      for (int j = 0; j < NWRITE; j++) begin
        if (win_port(wr_hit[e]) == j) wr_dat[e] = wd_a[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (clr_we && (clr_wa == AWIDTH'(e))) begin
        mem_q[e] <= '0;
      end else if (|wr_hit[e]) begin
        mem_q[e] <= wr_dat[e];
      end
    end
  end

  // Read path sees this edge's winning write first, so no separate forwarding network is needed
  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      ra_a[i] = ra[i*AWIDTH +: AWIDTH];
      rd_d[i] = '0;
      if (!busy && addr_ok(ra_a[i])) begin
        rd_d[i] = (|wr_hit[ra_a[i]]) ? wr_dat[ra_a[i]] : mem_q[ra_a[i]];
      end
    end
  end

  always_comb begin
    wcollide_d = 1'b0;
    for (int j = 0; j < NWRITE; j++) begin
      for (int k = j + 1; k < NWRITE; k++) begin
        if (wr_ok[j] && wr_ok[k] && (wa_a[j] == wa_a[k])) wcollide_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      wcollide_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREAD; i++) rd_q[i*DWIDTH +: DWIDTH] <= rd_d[i];
      wcollide_q <= wcollide_d;
    end
  end

  assign rd       = rd_q;
  assign wcollide = wcollide_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear sequencing, bypass, collisions, zero register.
// A second instance built with ZERO_REG=0 shares all inputs for the x0 comparison.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ra0, ra1, wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [1:0]  we;
  logic        clr;
  logic [9:0]  ra, wa;
  logic [63:0] wd, rd, rd_z;
  logic        busy, wcollide, busy_z, wcol_z;

  int n_cmp = 0;
  int n_err = 0;

  assign ra = {ra1, ra0};
  assign wa = {wa1, wa0};
  assign wd = {wd1, wd0};

  always #5 clk = ~clk;

  regfile_mp #(.ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd),
    .clr(clr), .busy(busy), .wcollide(wcollide)
  );

  regfile_mp #(.ZERO_REG(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_z), .we(we), .wa(wa), .wd(wd),
    .clr(clr), .busy(busy_z), .wcollide(wcol_z)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [31:0] e_rd0, e_rd1, e_z0;
    logic        e_col;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 2'b00; wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'h0; wd1 = 32'h0;
    ra0 = 5'd0; ra1 = 5'd0; clr = 1'b0;
  endtask

  // Counts samples with busy high; rd must read 0 at every one of them
  task automatic count_busy(output int n);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      chk("clear_rd0", rd[31:0], 32'h0);
      chk("clear_rd1", rd[63:32], 32'h0);
      if (!busy) break;
      n++;
      step();
    end
  endtask

  task automatic fill_all();
    for (int i = 0; i < 16; i++) begin
      we = 2'b11; wa0 = 5'(2*i); wa1 = 5'(2*i + 1);
      wd0 = 32'hC0DE0000 + 32'(2*i); wd1 = 32'hC0DE0000 + 32'(2*i + 1);
      step();
    end
    we = 2'b00;
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'(31 - i);
      step();
      chk("readall_rd0", rd[31:0], 32'h0);
      chk("readall_rd1", rd[63:32], 32'h0);
    end
    ra0 = 5'd0; ra1 = 5'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_inputs();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", rd[31:0] | rd[63:32], 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_wcol", 32'(wcollide), 32'h0);
    rst_n = 1'b1;
    count_busy(n);
    chk("init_busy_len", 32'(n), 32'd32);

    // Garbage, then reset out of READY with rd nonzero
    fill_all();
    ra0 = 5'd31; ra1 = 5'd0;
    step();
    chk("garbage_rd0", rd[31:0], 32'hC0DE001F);
    chk("garbage_x0_zero", rd[63:32], 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rd0", rd[31:0], 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    ra0 = 5'd0;
    count_busy(n);
    chk("rst2_busy_len", 32'(n), 32'd32);
    read_all_zero();

    // clr in READY with writes attempted during the clear window
    fill_all();
    ra1 = 5'd4;
    step();
    chk("prefill_rd1", rd[63:32], 32'hC0DE0004);
    ra1 = 5'd0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    we = 2'b11; wa0 = 5'd3; wa1 = 5'd4; wd0 = 32'h12345678; wd1 = 32'h9ABCDEF0;
    ra0 = 5'd3; ra1 = 5'd4;
    count_busy(n);
    chk("clr_busy_len", 32'(n), 32'd32);
    idle_inputs();
    read_all_zero();

    // clr held high through the whole clear: must not restart
    clr = 1'b1;
    step();
    count_busy(n);
    clr = 1'b0;
    chk("clr_hold_busy_len", 32'(n), 32'd32);

    // Reset at clear cycle 10
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (10) step();
    chk("midclr_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midclr_rst_rd", rd[31:0] | rd[63:32], 32'h0);
    chk("midclr_rst_busy", 32'(busy), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    count_busy(n);
    chk("midclr_busy_len", 32'(n), 32'd32);

    //          we     wa0   wa1   wd0           wd1           ra0   ra1   e_rd0         e_rd1         e_z0          col
    vt[0] = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[1] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0};
    vt[2] = '{2'b11, 5'd7, 5'd7, 32'h11,       32'h22,       5'd7, 5'd5, 32'h22,       32'hDEADBEEF, 32'h22,       1'b1};
    vt[3] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd7, 5'd7, 32'h22,       32'h22,       32'h22,       1'b0};
    vt[4] = '{2'b11, 5'd3, 5'd4, 32'h33,       32'h44,       5'd3, 5'd4, 32'h33,       32'h44,       32'h33,       1'b0};
    vt[5] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd4, 5'd3, 32'h44,       32'h33,       32'h44,       1'b0};
    vt[6] = '{2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 1'b0};
    vt[7] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0};
    vt[8] = '{2'b10, 5'd0, 5'd9, 32'h0,        32'hA5A5,     5'd9, 5'd9, 32'hA5A5,     32'hA5A5,     32'hA5A5,     1'b0};
    vt[9] = '{2'b10, 5'd9, 5'd9, 32'h1,        32'h2,        5'd9, 5'd7, 32'h2,        32'h22,       32'h2,        1'b0};

    for (int v = 0; v < 10; v++) begin
      we = vt[v].we; wa0 = vt[v].wa0; wa1 = vt[v].wa1;
      wd0 = vt[v].wd0; wd1 = vt[v].wd1; ra0 = vt[v].ra0; ra1 = vt[v].ra1;
      step();
      chk($sformatf("vec%0d_rd0", v), rd[31:0], vt[v].e_rd0);
      chk($sformatf("vec%0d_rd1", v), rd[63:32], vt[v].e_rd1);
      chk($sformatf("vec%0d_wcol", v), 32'(wcollide), 32'(vt[v].e_col));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'h0);
      chk($sformatf("vec%0d_z_rd0", v), rd_z[31:0], vt[v].e_z0);
    end

    // Collision pulse lasts a single cycle
    idle_inputs();
    we = 2'b11; wa0 = 5'd12; wa1 = 5'd12; wd0 = 32'h5; wd1 = 32'h6;
    step();
    we = 2'b00; ra0 = 5'd12;
    chk("col_pulse_hi", 32'(wcollide), 32'h1);
    step();
    chk("col_pulse_lo", 32'(wcollide), 32'h0);
    chk("col_winner", rd[31:0], 32'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
